pll_lock_supervisor: RTL and testbench
======================================

# pll_lock_supervisor

Parametrised lock supervisor for up to NUM_CH PLL instances running from a common reference clock. Per channel it does four things:
- drives the PLL reset;
- synchronises and qualifies the raw `locked` signal;
- holds the downstream clock-domain reset until lock has been stable for a programmable time;
- counts loss-of-lock events.

It sits between the PLL wrappers and the per-domain reset trees, and replaces ad-hoc use of raw `locked` as a reset.

## Interface
Parameters:
- NUM_CH, 2: number of supervised PLL channels (1–8).
- RST_CYCLES, 16: length of the pll_rst pulse in refclk cycles (≥2).
- STABLE_CYCLES, 1024: consecutive synchronised-locked cycles required before releasing dom_rst (≥1).
- TIMEOUT_CYCLES, 1048576: cycles allowed in WAIT_LOCK before a timeout event (≥2).
- LOL_W, 8: width of each loss-of-lock counter.

Ports:
- refclk  in  1  supervisor clock; one clock only. Reset is asynchronous and active-high.
- rst  in  1  asynchronous, active-high reset.
- pll_locked  in  NUM_CH  raw PLL lock indications, asynchronous to refclk.
- clr_stat  in  1  synchronous pulse; clears lol_cnt and timeout_flag.
- pll_rst  out  NUM_CH  reset to each PLL, active-high.
- dom_rst  out  NUM_CH  downstream domain reset, active-high.
- lol_cnt  out  NUM_CH*LOL_W  packed saturating loss-of-lock counters; channel i is at [i*LOL_W +: LOL_W].
- timeout_flag  out  NUM_CH  sticky lock-timeout flags.
- all_ok  out  1  high when every channel is in RUN.

## Operation
- Each channel has a 2-flop synchroniser on pll_locked[i], producing lk_s. All FSM decisions use lk_s only.
- The per-channel FSM states are RST_PLL, WAIT_LOCK, STABLE and RUN. A single counter per channel, sized to the maximum of the three limits, is cleared on every state entry.
- RST_PLL
  - pll_rst=1, dom_rst=1.
  - After RST_CYCLES cycles → WAIT_LOCK.
- WAIT_LOCK
  - pll_rst=0, dom_rst=1.
  - lk_s=1 → STABLE.
  - Counter reaches TIMEOUT_CYCLES-1 with lk_s=0 → timeout event (see Configuration).
- STABLE
  - dom_rst=1.
  - lk_s=0 → WAIT_LOCK; the counter restarts and no lol increment occurs.
  - STABLE_CYCLES consecutive cycles with lk_s=1 → RUN.
- RUN
  - dom_rst=0.
  - lk_s=0 → WAIT_LOCK, dom_rst=1 on the next edge, and lol_cnt[i] increments.
- lol_cnt saturates at 2^LOL_W-1 and does not wrap.
- timeout_flag[i] is set on every timeout event.
- clr_stat clears all lol_cnt and timeout_flag values in the following cycle. If clr_stat coincides with an increment or set event, the clear wins.
- all_ok = AND of (state==RUN) over all channels, registered.
- Channels are fully independent; there is no cross-channel sequencing.

## Timing
- Reset values:
  - pll_rst = all 1s.
  - dom_rst = all 1s.
  - lol_cnt = 0.
  - timeout_flag = 0.
  - all_ok = 0.
  - All FSMs in RST_PLL with counter 0.
  - Synchronisers cleared.
- All outputs are registered. No combinational path exists from any input to any output.
- Synchroniser latency is 2 cycles from a pll_locked edge to lk_s.
- From lk_s rising in WAIT_LOCK, dom_rst falls exactly 1 + STABLE_CYCLES cycles later: one cycle to enter STABLE, then the stable count.
- Loss of lock in RUN: dom_rst rises 3 cycles after the pll_locked falling edge (2 synchroniser cycles + 1 register).
- A pll_locked glitch shorter than one refclk cycle may be missed. Any glitch that is captured is treated as a full loss of lock.
- Asserting rst mid-operation returns every channel to RST_PLL immediately and asynchronously. The statistics counters are also cleared.

## Configuration
- Macro: PLL_LOCK_SUPERVISOR_RETRY_EN.
- Defined: a timeout event sets timeout_flag and transitions WAIT_LOCK → RST_PLL, re-pulsing pll_rst. Retries are unlimited.
- Undefined: a timeout event sets timeout_flag only. The FSM stays in WAIT_LOCK with the counter held at its final value, and pll_rst stays 0. A later lk_s=1 still proceeds to STABLE.

## Structure
- Package pll_lock_supervisor_pkg contains:
  - the FSM state enum typedef (st_t: ST_RST_PLL, ST_WAIT_LOCK, ST_STABLE, ST_RUN);
  - a constant function returning the counter width from the three cycle limits.
- Sub-module pll_sup_ch is one channel: synchroniser, FSM, counter, lol counter and timeout flag. It is instantiated NUM_CH times in a generate loop.
- The top level contains only the generate loop, the output packing and the all_ok register.

## Test plan
Bench parameters: NUM_CH=2, RST_CYCLES=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=32, LOL_W=2.

1. Release rst, then raise pll_locked[0] 10 cycles later → pll_rst[0] is high for exactly 4 cycles, dom_rst[0] falls 2+1+8 cycles after the pll_locked edge, and all_ok stays 0 while channel 1 is unlocked.
2. Lock both channels, then drop pll_locked[1] for 5 cycles → dom_rst[1] rises 3 cycles after the drop, lol_cnt[1]=1, and all_ok falls. Re-lock → dom_rst[1] is released after 11 more cycles.
3. In STABLE, drop pll_locked[0] for 2 cycles at count 6 → dom_rst[0] stays 1, lol_cnt[0] remains 0, and the stable count restarts from 0.
4. Generate 5 lock losses in RUN on channel 0 → lol_cnt[0] saturates at 3. Pulse clr_stat → lol_cnt[0]=0 on the next cycle.
5. Keep pll_locked[0]=0 → timeout_flag[0] sets 32 cycles after entering WAIT_LOCK.
   - With RETRY_EN: pll_rst[0] re-pulses for 4 cycles every 36 cycles.
   - Without RETRY_EN: pll_rst[0] stays 0.
6. Assert rst while both channels are in RUN → pll_rst and dom_rst are both 11 and all_ok=0 before the next refclk edge, and all counters are 0.

Source files
------------

// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
// Holds the per-channel FSM state encoding and the counter width function.
package pll_lock_supervisor_pkg;

  typedef enum logic [1:0] {
    ST_RST_PLL,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN
  } st_t;

  // One counter serves every state, so it must hold the largest terminal value.
  function automatic int cnt_width(input int rst_cycles, input int stable_cycles,
                                   input int timeout_cycles);
    int m;
    m = rst_cycles;
    if (stable_cycles > m) m = stable_cycles;
    if (timeout_cycles > m) m = timeout_cycles;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_sup_ch.sv
// One supervised PLL channel: lock synchroniser, sequencing FSM, loss-of-lock counter.
// PLL_LOCK_SUPERVISOR_RETRY_EN makes a lock timeout re-pulse the PLL reset.
module pll_sup_ch
  import pll_lock_supervisor_pkg::*;
#(
  parameter int RST_CYCLES     = 16,
  parameter int STABLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int LOL_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             locked,
  input  logic             clr_stat,
  output logic             pll_rst,
  output logic             dom_rst,
  output logic [LOL_W-1:0] lol_cnt,
  output logic             timeout_flag,
  output logic             run
);

  localparam int CW = cnt_width(RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(TIMEOUT_CYCLES - 1);

  logic          sync_p0;
  logic          lk_s;
  st_t           state;
  logic [CW-1:0] cnt;
  logic          expired;
  logic          timeout_evt;
  logic          lol_evt;

  // Stage boundary: two-flop synchroniser for the asynchronous lock input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      lk_s    <= 1'b0;
    end else begin
      sync_p0 <= locked;
      lk_s    <= sync_p0;
    end
  end

  // expired keeps a held timeout counter from re-firing every cycle
  assign timeout_evt = (state == ST_WAIT_LOCK) && !lk_s && (cnt == TO_LAST) && !expired;
  assign lol_evt     = (state == ST_RUN) && !lk_s;
  assign run         = (state == ST_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_RST_PLL;
      cnt     <= '0;
      pll_rst <= 1'b1;
      dom_rst <= 1'b1;
      expired <= 1'b0;
    end else begin
      case (state)
        ST_RST_PLL: begin
          if (cnt == RST_LAST) begin
            state   <= ST_WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
            expired <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (lk_s) begin
            state <= ST_STABLE;
            cnt   <= '0;
          end else if (cnt == TO_LAST) begin
`ifdef PLL_LOCK_SUPERVISOR_RETRY_EN
            state   <= ST_RST_PLL;
            cnt     <= '0;
            pll_rst <= 1'b1;
`else
            expired <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STABLE: begin
          if (!lk_s) begin
            state   <= ST_WAIT_LOCK;
            cnt     <= '0;
            expired <= 1'b0;
          end else if (cnt == STABLE_LAST) begin
            state   <= ST_RUN;
            cnt     <= '0;
            dom_rst <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (!lk_s) begin
            state   <= ST_WAIT_LOCK;
            cnt     <= '0;
            dom_rst <= 1'b1;
            expired <= 1'b0;
          end
        end
        default: begin
          state   <= ST_RST_PLL;
          cnt     <= '0;
          pll_rst <= 1'b1;
          dom_rst <= 1'b1;
        end
      endcase
    end
  end

  // Statistics: clear has priority over a same-cycle event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lol_cnt      <= '0;
      timeout_flag <= 1'b0;
    end else if (clr_stat) begin
      lol_cnt      <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (lol_evt && (lol_cnt != '1)) lol_cnt <= lol_cnt + 1'b1;
      if (timeout_evt) timeout_flag <= 1'b1;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Top of the PLL lock supervisor: NUM_CH independent channels plus a registered all_ok.
// Build with PLL_LOCK_SUPERVISOR_RETRY_EN to retry the PLL reset after a lock timeout.
module pll_lock_supervisor
  import pll_lock_supervisor_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int RST_CYCLES     = 16,
  parameter int STABLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int LOL_W          = 8
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       pll_locked,
  input  logic                    clr_stat,
  output logic [NUM_CH-1:0]       pll_rst,
  output logic [NUM_CH-1:0]       dom_rst,
  output logic [NUM_CH*LOL_W-1:0] lol_cnt,
  output logic [NUM_CH-1:0]       timeout_flag,
  output logic                    all_ok
);

  logic [NUM_CH-1:0] run;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pll_sup_ch #(
      .RST_CYCLES    (RST_CYCLES),
      .STABLE_CYCLES (STABLE_CYCLES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .LOL_W         (LOL_W)
    ) u_ch (
      .clk         (refclk),
      .rst         (rst),
      .locked      (pll_locked[i]),
      .clr_stat    (clr_stat),
      .pll_rst     (pll_rst[i]),
      .dom_rst     (dom_rst[i]),
      .lol_cnt     (lol_cnt[i*LOL_W +: LOL_W]),
      .timeout_flag(timeout_flag[i]),
      .run         (run[i])
    );
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) all_ok <= 1'b0;
    else     all_ok <= &run;
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: expectations are queued with the cycle they apply to.
// A negedge monitor pops and compares every entry due in the current cycle.
module tb_pll_lock_supervisor;

  localparam int NUM_CH = 2;
  localparam int LOL_W  = 2;

  logic                    refclk = 1'b0;
  logic                    rst;
  logic [NUM_CH-1:0]       pll_locked;
  logic                    clr_stat;
  logic [NUM_CH-1:0]       pll_rst;
  logic [NUM_CH-1:0]       dom_rst;
  logic [NUM_CH*LOL_W-1:0] lol_cnt;
  logic [NUM_CH-1:0]       timeout_flag;
  logic                    all_ok;

  pll_lock_supervisor #(
    .NUM_CH(NUM_CH), .RST_CYCLES(4), .STABLE_CYCLES(8), .TIMEOUT_CYCLES(32), .LOL_W(LOL_W)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .clr_stat(clr_stat),
    .pll_rst(pll_rst), .dom_rst(dom_rst), .lol_cnt(lol_cnt),
    .timeout_flag(timeout_flag), .all_ok(all_ok)
  );

  always #5 refclk = ~refclk;

  int cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  typedef struct {
    int    cyc;
    int    sel;
    int    val;
    string nm;
  } exp_t;

  exp_t sbq[$];
  exp_t keep_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic push(input int c, input int s, input int v, input string n);
    exp_t e;
    e.cyc = c; e.sel = s; e.val = v; e.nm = n;
    sbq.push_back(e);
  endtask

  // Advance to just after the active edge that brings the cycle count to c.
  task automatic to_cyc(input int c);
    while (cyc < c) begin
      @(posedge refclk);
      #1;
    end
  endtask

  function automatic int actual(input int s);
    case (s)
      0:  return int'(pll_rst[0]);
      1:  return int'(pll_rst[1]);
      2:  return int'(dom_rst[0]);
      3:  return int'(dom_rst[1]);
      4:  return int'(lol_cnt[1:0]);
      5:  return int'(lol_cnt[3:2]);
      6:  return int'(timeout_flag[0]);
      7:  return int'(timeout_flag[1]);
      8:  return int'(all_ok);
      9:  return int'(pll_rst);
      10: return int'(dom_rst);
      11: return int'(lol_cnt);
      12: return int'(timeout_flag);
      default: return -1;
    endcase
  endfunction

  always @(negedge refclk) begin
    int a;
    keep_q.delete();
    foreach (sbq[i]) begin
      if (sbq[i].cyc == cyc) begin
        a = actual(sbq[i].sel);
        n_cmp++;
        if (a != sbq[i].val) begin
          n_err++;
          $display("FAIL %s @cyc %0d: got %0d expected %0d", sbq[i].nm, cyc, a, sbq[i].val);
        end
      end else if (sbq[i].cyc < cyc) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s: expectation for cyc %0d never checked", sbq[i].nm, sbq[i].cyc);
      end else begin
        keep_q.push_back(sbq[i]);
      end
    end
    sbq = keep_q;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    pll_locked = '0;
    clr_stat = 1'b0;

    // Reset state
    to_cyc(2);
    push(2, 9, 3, "rst_pll_rst");
    push(2, 10, 3, "rst_dom_rst");
    push(2, 11, 0, "rst_lol_cnt");
    push(2, 12, 0, "rst_timeout_flag");
    push(2, 8, 0, "rst_all_ok");
    to_cyc(3);
    rst = 1'b0;

    // PLL reset pulse is four cycles after release
    push(3, 0, 1, "pll_rst0_first");
    push(6, 0, 1, "pll_rst0_last");
    push(7, 0, 0, "pll_rst0_released");

    // Channel 0 lock: release 11 cycles after the input edge
    to_cyc(13);
    pll_locked[0] = 1'b1;
    push(23, 2, 1, "dom_rst0_held");
    push(24, 2, 0, "dom_rst0_released");
    push(25, 8, 0, "all_ok_ch1_unlocked");
    push(25, 3, 1, "dom_rst1_held");

    // Channel 1 timeout 32 cycles after entering WAIT_LOCK
    push(38, 7, 0, "tf1_before");
    push(39, 7, 1, "tf1_set");
`ifdef PLL_LOCK_SUPERVISOR_RETRY_EN
    push(38, 1, 0, "retry_pll_rst1_before");
    push(39, 1, 1, "retry_pll_rst1_start");
    push(42, 1, 1, "retry_pll_rst1_end");
    push(43, 1, 0, "retry_pll_rst1_released");
`else
    push(39, 1, 0, "noretry_pll_rst1_low");
    push(42, 1, 0, "noretry_pll_rst1_stays_low");
`endif

    // Channel 1 lock, then all_ok
    to_cyc(45);
    pll_locked[1] = 1'b1;
    push(55, 3, 1, "dom_rst1_held_stable");
    push(56, 3, 0, "dom_rst1_released");
    push(56, 8, 0, "all_ok_lag");
    push(57, 8, 1, "all_ok_set");

    // Channel 1 loss of lock in RUN for 5 cycles
    to_cyc(60);
    pll_locked[1] = 1'b0;
    push(62, 3, 0, "dom_rst1_before_loss");
    push(63, 3, 1, "dom_rst1_loss");
    push(62, 5, 0, "lol1_before");
    push(63, 5, 1, "lol1_incr");
    push(63, 8, 1, "all_ok_before_drop");
    push(64, 8, 0, "all_ok_drop");
    to_cyc(65);
    pll_locked[1] = 1'b1;
    push(75, 3, 1, "dom_rst1_relock_held");
    push(76, 3, 0, "dom_rst1_relock_released");
    push(77, 8, 1, "all_ok_back");

    // Five lock losses on channel 0 saturate its 2-bit counter
    push(82, 4, 0, "lol0_before_losses");
    for (int k = 0; k < 5; k++) begin
      n = 80 + 20 * k;
      to_cyc(n);
      pll_locked[0] = 1'b0;
      push(n + 3, 4, (k < 3) ? k + 1 : 3, "lol0_count");
      push(n + 3, 2, 1, "lol_dom_rst0");
      to_cyc(n + 2);
      pll_locked[0] = 1'b1;
    end
    push(172, 2, 1, "dom_rst0_last_relock_held");
    push(173, 2, 0, "dom_rst0_last_relock_released");

    // Clear statistics
    to_cyc(175);
    clr_stat = 1'b1;
    push(175, 4, 3, "lol0_saturated");
    push(175, 7, 1, "tf1_sticky");
    push(176, 11, 0, "clr_lol_cnt");
    push(176, 12, 0, "clr_timeout_flag");
    to_cyc(176);
    clr_stat = 1'b0;

    // Clear coinciding with a loss-of-lock increment wins
    to_cyc(180);
    pll_locked[0] = 1'b0;
    to_cyc(182);
    pll_locked[0] = 1'b1;
    clr_stat = 1'b1;
    push(183, 2, 1, "clr_race_dom_rst0");
    push(183, 4, 0, "clr_beats_incr");
    to_cyc(183);
    clr_stat = 1'b0;

    // Drop during STABLE restarts the stable count without counting a loss
    to_cyc(188);
    pll_locked[0] = 1'b0;
    push(193, 2, 1, "stable_drop_dom_rst0_held");
    push(200, 2, 1, "stable_restart_held");
    push(201, 2, 0, "stable_restart_released");
    push(201, 4, 0, "stable_drop_no_lol");
    to_cyc(190);
    pll_locked[0] = 1'b1;

    // Another channel 1 loss so the counters are non-zero before reset
    to_cyc(204);
    pll_locked[1] = 1'b0;
    push(207, 5, 1, "lol1_after_clear");
    to_cyc(206);
    pll_locked[1] = 1'b1;

    // Asynchronous reset while both channels run
    to_cyc(222);
    push(222, 8, 1, "pre_rst_all_ok");
    push(222, 11, 4, "pre_rst_lol_cnt");
    push(222, 10, 0, "pre_rst_dom_rst");
    push(222, 9, 0, "pre_rst_pll_rst");
    to_cyc(223);
    rst = 1'b1;
    push(223, 9, 3, "async_rst_pll_rst");
    push(223, 10, 3, "async_rst_dom_rst");
    push(223, 8, 0, "async_rst_all_ok");
    push(223, 11, 0, "async_rst_lol_cnt");
    push(223, 12, 0, "async_rst_timeout_flag");

    to_cyc(226);
    if (sbq.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL leftover: got %0d pending expectations, expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
